// File: rtl/alu_seq_unit.sv
// ============================================================================
//  Module   : alu_seq_unit
//  Brief    : Handshaked multi-cycle ALU; iterative shift-add multiply,
//             single-cycle execute for all other opcodes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [OPRN_WIDTH-1:0] c_op_add = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] c_op_sub = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] c_op_mul = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] c_op_srl = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] c_op_sll = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] c_op_and = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] c_op_or  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] c_op_nor = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] c_op_slt = OPRN_WIDTH'(9);

  localparam logic [DATA_WIDTH-1:0] c_dw   = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [CW-1:0]         c_last = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         c_one  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_op1, r_op2;
  logic [OPRN_WIDTH-1:0] r_oprn;
  logic [DATA_WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_zero;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic                  w_shamt_big;
  logic                  w_lt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = (r_oprn == c_op_mul) ? S_MUL : S_IDLE;
      S_MUL:   if (r_cnt == c_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift amounts are unsigned; anything at or beyond the width clears the result.
  assign w_shamt_big = (r_op2 >= c_dw);
  assign w_lt        = ($signed(r_op1) < $signed(r_op2));
  assign w_acc_nxt   = r_acc + (r_mcand[0] ? r_mplier : '0);

  always_comb begin
    w_alu = '0;
    case (r_oprn)
      c_op_add: w_alu = r_op1 + r_op2;
      c_op_sub: w_alu = r_op1 - r_op2;
      c_op_srl: w_alu = w_shamt_big ? '0 : (r_op1 >> r_op2);
      c_op_sll: w_alu = w_shamt_big ? '0 : (r_op1 << r_op2);
      c_op_and: w_alu = r_op1 & r_op2;
      c_op_or:  w_alu = r_op1 | r_op2;
      c_op_nor: w_alu = ~(r_op1 | r_op2);
      c_op_slt: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_oprn   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op1  <= op1;
            r_op2  <= op2;
            r_oprn <= oprn;
          end
        end
        S_EXEC: begin
          if (r_oprn == c_op_mul) begin
            r_acc    <= '0;
            r_mcand  <= r_op1;
            r_mplier <= r_op2;
            r_cnt    <= '0;
          end else begin
            r_out  <= w_alu;
            r_zero <= (w_alu == '0);
            r_done <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand >> 1;
          r_mplier <= r_mplier << 1;
          r_cnt    <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            r_out  <= w_acc_nxt;
            r_zero <= (w_acc_nxt == '0);
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_EXEC) || (r_state == S_MUL);
  assign done = r_done;
  assign out  = r_out;
  assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
// ============================================================================
//  Module   : tb_alu_seq_unit
//  Brief    : Directed self-checking bench for alu_seq_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1, op2;
  logic [5:0]  oprn;
  logic        busy, done, zero;
  logic [31:0] out;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq_unit #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op1  (op1),
    .op2  (op2),
    .oprn (oprn),
    .busy (busy),
    .done (done),
    .out  (out),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Called one step after a rising edge; returns one step after the DONE edge,
  // so consecutive calls issue back-to-back requests.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input int exp_lat,
                       input logic [31:0] exp_out, input logic exp_zero);
    int lat;
    bit got;
    op1 = a; op2 = b; oprn = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_out"}, out, exp_out);
    check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  initial begin
    int n_done, lat5;
    logic [31:0] out5;

    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; oprn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_out",  out, 32'd0);
    check_val("rst_zero", {31'd0, zero}, 32'd1);

    do_op("add",  32'd10, 32'd10, 6'd1, 1, 32'd20, 1'b0);
    do_op("sub",  32'd10, 32'd10, 6'd2, 1, 32'd0,  1'b1);
    do_op("subw", 32'd0,  32'd1,  6'd2, 1, 32'hFFFFFFFF, 1'b0);
    do_op("addw", 32'hFFFFFFFF, 32'd1, 6'd1, 1, 32'd0, 1'b1);

    // Result is held and DONE drops once nothing new is requested.
    do_op("and",  32'h0000F0F0, 32'h0000FF00, 6'd6, 1, 32'h0000F000, 1'b0);
    @(posedge clk); #1;
    check_val("hold_done", {31'd0, done}, 32'd0);
    check_val("hold_out",  out, 32'h0000F000);
    @(posedge clk); #1;

    do_op("mul",   -32'sd15, 32'd42, 6'd3, 33, 32'hFFFFFD8A, 1'b0);
    do_op("mul0",  32'd23, 32'd0,  6'd3, 33, 32'd0, 1'b1);
    do_op("mulnn", -32'sd7, -32'sd6, 6'd3, 33, 32'd42, 1'b0);
    do_op("multr", 32'h00010000, 32'h00010000, 6'd3, 33, 32'd0, 1'b1);

    do_op("sll31", 32'd1, 32'd31, 6'd5, 1, 32'h80000000, 1'b0);
    do_op("srl31", 32'h80000000, 32'd31, 6'd4, 1, 32'd1, 1'b0);
    do_op("sll32", 32'd5, 32'd32, 6'd5, 1, 32'd0, 1'b1);
    do_op("srlbig", 32'hFFFFFFFF, 32'h80000000, 6'd4, 1, 32'd0, 1'b1);
    do_op("slteq", -32'sd30, -32'sd30, 6'd9, 1, 32'd0, 1'b1);
    do_op("sltlt", -32'sd15, 32'd15, 6'd9, 1, 32'd1, 1'b0);
    do_op("nor",   32'd0, 32'd0, 6'd8, 1, 32'hFFFFFFFF, 1'b0);
    do_op("or",    32'h0000F0F0, 32'h00000F0F, 6'd7, 1, 32'h0000FFFF, 1'b0);
    do_op("undef0",  32'd5, 32'd5, 6'd0,  1, 32'd0, 1'b1);
    do_op("undef12", 32'd5, 32'd5, 6'd12, 1, 32'd0, 1'b1);

    // Inputs changing and START pulsing while busy must not disturb the multiply.
    @(posedge clk); #1;
    op1 = -32'sd15; op2 = 32'd42; oprn = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    op1 = 32'd7; oprn = 6'd1;
    n_done = 0; lat5 = 0; out5 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        n_done++;
        lat5 = i;
        out5 = out;
      end
    end
    check_val("latch_ndone", n_done, 32'd1);
    check_val("latch_lat",   lat5, 32'd33);
    check_val("latch_out",   out5, 32'hFFFFFD8A);

    // Abort a multiply at iteration 10.
    op1 = 32'd3; op2 = 32'd4; oprn = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_out",  out, 32'd0);
    check_val("abort_zero", {31'd0, zero}, 32'd1);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    check_val("abort_ndone", n_done, 32'd0);
    do_op("post", 32'd25, -32'sd25, 6'd1, 1, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
